// File: rtl/axireg_mc.sv
`default_nettype none
// ============================================================================
//  Module      : axireg_mc
//  Description : AXI4-Lite control/status register block for up to 16
//                sorting-network channels. Per-channel beat count, start and
//                writeback pulses, busy/done/err status, global sticky DONE
//                (W1C), interrupt enable and registered level interrupt.
//                Optional macro AXIREG_MC_PERF_EN adds a 32-bit saturating
//                busy-cycle counter per channel at channel offset +0xC.
//  Revision    : 1.0 - initial release
// ============================================================================
module axireg_mc #(
   parameter int SADRW = 32,
   parameter int NCH   = 4,
   parameter int BEATW = 20
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [SADRW-1:0]     i_araddr,
   input  logic                 i_arvalid,
   output logic                 o_arready,
   output logic [31:0]          o_rdata,
   output logic [1:0]           o_rresp,
   output logic                 o_rvalid,
   input  logic                 i_rready,
   input  logic [SADRW-1:0]     i_awaddr,
   input  logic                 i_awvalid,
   output logic                 o_awready,
   input  logic [31:0]          i_wdata,
   input  logic [3:0]           i_wstrb,
   input  logic                 i_wvalid,
   output logic                 o_wready,
   output logic [1:0]           o_bresp,
   output logic                 o_bvalid,
   input  logic                 i_bready,
   output logic [NCH*BEATW-1:0] o_beat,
   output logic [NCH-1:0]       o_start,
   input  logic [NCH-1:0]       i_done,
   output logic [NCH-1:0]       o_writeback,
   output logic                 o_irq
);

   localparam logic [31:0] C_ID     = {8'hA5, 8'(BEATW), 8'(NCH), 8'h02};
   localparam logic [1:0]  C_OKAY   = 2'b00;
   localparam logic [1:0]  C_SLVERR = 2'b10;
   localparam logic [4:0]  C_NCH    = 5'(NCH);

   typedef enum logic [0:0] {WS_COLLECT = 1'b0, WS_RESP = 1'b1} wstate_t;

   wstate_t          r_wstate, w_wstate_nx;
   logic             r_aw_got, r_w_got, w_aw_hs, w_w_hs, w_ar_hs, w_commit;
   logic [11:0]      r_awaddr, w_wa, w_ra;
   logic [31:0]      r_wdata, w_wd, w_m, w_rd_data, r_rdata;
   logic [3:0]       r_wstrb, w_ws;
   logic [1:0]       w_rd_resp, r_rresp, r_bresp;
   logic             r_rvalid, r_irq, w_act, w_irq_en_we, w_unused;
   logic [BEATW-1:0] r_beat [NCH];
   logic [NCH-1:0]   r_irq_en, r_done, r_busy, r_err, r_start, r_wb;
   logic [NCH-1:0]   w_done_clr, w_beat_we, w_start_req, w_wb_req, w_err_clr;
   logic [NCH-1:0]   w_start_ok, w_start_bad;
`ifdef AXIREG_MC_PERF_EN
   logic [31:0]      r_perf [NCH];
`endif

   // Word address a[11:2] decodes to an existing register
   function automatic logic f_mapped(input logic [9:0] a);
      logic m;
      m = 1'b0;
      if (a[9:6] == 4'h0)
         m = (a[5:0] <= 6'd2);
      else if (a[9:6] == 4'h1 && {1'b0, a[5:2]} < C_NCH)
`ifdef AXIREG_MC_PERF_EN
         m = 1'b1;
`else
         m = (a[1:0] != 2'b11);
`endif
      return m;
   endfunction

   assign w_ra        = i_araddr[11:0];
   assign w_ar_hs     = i_arvalid & o_arready;
   assign o_arready   = ~r_rvalid;
   assign o_rvalid    = r_rvalid;
   assign o_rdata     = r_rdata;
   assign o_rresp     = r_rresp;
   assign o_awready   = (r_wstate == WS_COLLECT) & ~r_aw_got;
   assign o_wready    = (r_wstate == WS_COLLECT) & ~r_w_got;
   assign w_aw_hs     = i_awvalid & o_awready;
   assign w_w_hs      = i_wvalid & o_wready;
   assign o_bvalid    = (r_wstate == WS_RESP);
   assign o_bresp     = r_bresp;
   assign o_start     = r_start;
   assign o_writeback = r_wb;
   assign o_irq       = r_irq;
   // Commit uses whichever half was captured earlier, or the live bus value
   assign w_wa        = r_aw_got ? r_awaddr : i_awaddr[11:0];
   assign w_wd        = r_w_got  ? r_wdata  : i_wdata;
   assign w_ws        = r_w_got  ? r_wstrb  : i_wstrb;
   assign w_m         = {{8{w_ws[3]}}, {8{w_ws[2]}}, {8{w_ws[1]}}, {8{w_ws[0]}}};
   assign w_start_ok  = w_start_req & ~r_busy;
   assign w_start_bad = w_start_req & r_busy;
   assign w_unused    = ^{i_araddr, i_awaddr, w_wd, w_m, w_ra, w_wa};

   generate
      for (genvar c = 0; c < NCH; c++) begin : g_beat
         assign o_beat[c*BEATW +: BEATW] = r_beat[c];
      end
   endgenerate

   // Write FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_wstate <= WS_COLLECT;
      else          r_wstate <= w_wstate_nx;
   end

   // Write FSM next state: commit once both AW and W are in hand
   always_comb begin
      w_wstate_nx = r_wstate;
      w_commit    = 1'b0;
      case (r_wstate)
         WS_COLLECT: if ((r_aw_got | w_aw_hs) & (r_w_got | w_w_hs)) begin
            w_commit    = 1'b1;
            w_wstate_nx = WS_RESP;
         end
         WS_RESP: if (i_bready) w_wstate_nx = WS_COLLECT;
         default: w_wstate_nx = WS_COLLECT;
      endcase
   end

   // Capture AW/W halves independently and the B response at commit
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_aw_got <= 1'b0;  r_w_got <= 1'b0;
         r_awaddr <= '0;    r_wdata <= '0;  r_wstrb <= '0;  r_bresp <= C_OKAY;
      end else begin
         if (r_wstate == WS_RESP && i_bready) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
         end else begin
            if (w_aw_hs) begin r_aw_got <= 1'b1; r_awaddr <= i_awaddr[11:0]; end
            if (w_w_hs)  begin r_w_got  <= 1'b1; r_wdata <= i_wdata; r_wstrb <= i_wstrb; end
         end
         if (w_commit)
            r_bresp <= (w_ws == 4'd0 || f_mapped(w_wa[11:2])) ? C_OKAY : C_SLVERR;
      end
   end

   // Write decode into per-register enables
   always_comb begin
      w_act       = w_commit && (w_ws != 4'd0) && f_mapped(w_wa[11:2]);
      w_irq_en_we = w_act && (w_wa[11:2] == 10'd1);
      w_done_clr  = (w_act && w_wa[11:2] == 10'd2 && w_ws[0]) ? w_wd[NCH-1:0] : '0;
      w_beat_we   = '0;
      w_start_req = '0;
      w_wb_req    = '0;
      w_err_clr   = '0;
      for (int c = 0; c < NCH; c++) begin
         if (w_act && w_wa[11:8] == 4'h1 && w_wa[7:4] == 4'(c)) begin
            w_beat_we[c]   = (w_wa[3:2] == 2'd0);
            w_start_req[c] = (w_wa[3:2] == 2'd1) && w_ws[0] && w_wd[0];
            w_wb_req[c]    = (w_wa[3:2] == 2'd1) && w_ws[0] && w_wd[1];
            w_err_clr[c]   = (w_wa[3:2] == 2'd2) && w_ws[0] && w_wd[2];
         end
      end
   end

   // Register file, status flags, pulses and interrupt
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_irq_en <= '0;  r_done <= '0;  r_busy <= '0;  r_err <= '0;
         r_start  <= '0;  r_wb   <= '0;  r_irq  <= 1'b0;
         for (int c = 0; c < NCH; c++) r_beat[c] <= '0;
      end else begin
         if (w_irq_en_we)
            r_irq_en <= (r_irq_en & ~w_m[NCH-1:0]) | (w_wd[NCH-1:0] & w_m[NCH-1:0]);
         // i_done set overrides a simultaneous W1C; accepted start overrides done
         r_done  <= (r_done & ~w_done_clr) | i_done;
         r_busy  <= w_start_ok | (r_busy & ~i_done);
         r_err   <= (r_err & ~w_err_clr) | w_start_bad;
         r_start <= w_start_ok;
         r_wb    <= w_wb_req;
         r_irq   <= |(r_done & r_irq_en);
         for (int c = 0; c < NCH; c++)
            if (w_beat_we[c])
               r_beat[c] <= (r_beat[c] & ~w_m[BEATW-1:0]) | (w_wd[BEATW-1:0] & w_m[BEATW-1:0]);
      end
   end

`ifdef AXIREG_MC_PERF_EN
   // Busy-cycle counters: clear on accepted start, saturate, hold after done
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < NCH; c++) r_perf[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (w_start_ok[c])                     r_perf[c] <= '0;
            else if (r_busy[c] && r_perf[c] != '1) r_perf[c] <= r_perf[c] + 32'd1;
         end
      end
   end
`endif

   // Read mux on the live AR address
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = f_mapped(w_ra[11:2]) ? C_OKAY : C_SLVERR;
      if (w_ra[11:8] == 4'h0) begin
         case (w_ra[7:2])
            6'd0:    w_rd_data = C_ID;
            6'd1:    w_rd_data[NCH-1:0] = r_irq_en;
            6'd2:    w_rd_data[NCH-1:0] = r_done;
            default: ;
         endcase
      end else if (w_ra[11:8] == 4'h1) begin
         for (int c = 0; c < NCH; c++) begin
            if (w_ra[7:4] == 4'(c)) begin
               case (w_ra[3:2])
                  2'd0:    w_rd_data[BEATW-1:0] = r_beat[c];
                  2'd2:    w_rd_data[2:0] = {r_err[c], r_done[c], r_busy[c]};
`ifdef AXIREG_MC_PERF_EN
                  2'd3:    w_rd_data = r_perf[c];
`endif
                  default: ;
               endcase
            end
         end
      end
   end

   // Read response register: one-cycle latency, held until accepted
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rvalid <= 1'b0;  r_rdata <= '0;  r_rresp <= C_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;  r_rdata <= w_rd_data;  r_rresp <= w_rd_resp;
      end else if (r_rvalid && i_rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axireg_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axireg_mc
//  Description : Self-checking bench for axireg_mc (NCH=4, BEATW=20) using
//                directed items plus randomized register traffic checked
//                against a register-map level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axireg_mc;
   localparam int SADRW = 32;
   localparam int NCH   = 4;
   localparam int BEATW = 20;
`ifdef AXIREG_MC_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic i_clk = 1'b0, i_rst_n = 1'b0;
   logic [SADRW-1:0] i_araddr = '0, i_awaddr = '0;
   logic i_arvalid = 0, i_rready = 0, i_awvalid = 0, i_wvalid = 0, i_bready = 0;
   logic [31:0] i_wdata = '0;
   logic [3:0]  i_wstrb = '0;
   logic [NCH-1:0] i_done = '0;
   logic o_arready, o_rvalid, o_awready, o_wready, o_bvalid, o_irq;
   logic [31:0] o_rdata;
   logic [1:0]  o_rresp, o_bresp;
   logic [NCH*BEATW-1:0] o_beat;
   logic [NCH-1:0] o_start, o_writeback;

   axireg_mc #(.SADRW(SADRW), .NCH(NCH), .BEATW(BEATW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_araddr(i_araddr), .i_arvalid(i_arvalid), .o_arready(o_arready),
      .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rvalid(o_rvalid), .i_rready(i_rready),
      .i_awaddr(i_awaddr), .i_awvalid(i_awvalid), .o_awready(o_awready),
      .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
      .o_beat(o_beat), .o_start(o_start), .i_done(i_done),
      .o_writeback(o_writeback), .o_irq(o_irq)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (register-map level) ----------------
   logic [BEATW-1:0] m_beat [NCH];
   logic [3:0] m_irq_en, m_done, m_busy, m_err;

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) m_beat[c] = '0;
      m_irq_en = 0; m_done = 0; m_busy = 0; m_err = 0;
   endtask

   function automatic bit m_mapped(input logic [11:0] a);
      int o = int'(a);
      if (o == 0 || o == 4 || o == 8) return 1'b1;
      if (o >= 256 && o < 256 + 16*NCH) return (o % 16 != 12) || PERF;
      return 1'b0;
   endfunction

   function automatic void m_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
      int o = int'(a);
      int c;
      d = 0;
      r = m_mapped(a) ? 2'b00 : 2'b10;
      if (o == 0) d = 32'hA514_0402;
      else if (o == 4) d = {28'd0, m_irq_en};
      else if (o == 8) d = {28'd0, m_done};
      else if (r == 2'b00) begin
         c = (o - 256) / 16;
         if (o % 16 == 0) d = {12'd0, m_beat[c]};
         else if (o % 16 == 8) d = {29'd0, m_err[c], m_done[c], m_busy[c]};
      end
   endfunction

   function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input logic [3:0] dm, output logic [1:0] resp,
                                   output logic [3:0] st, output logic [3:0] wb);
      int o = int'(a[11:0]);
      int c;
      logic [31:0] m;
      st = 0; wb = 0;
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      resp = (s == 0 || m_mapped(a[11:0])) ? 2'b00 : 2'b10;
      if (s != 0 && m_mapped(a[11:0])) begin
         if (o == 4) m_irq_en = 4'(({28'd0, m_irq_en} & ~m) | (d & m));
         else if (o == 8) begin if (s[0]) m_done = m_done & ~d[3:0]; end
         else if (o >= 256) begin
            c = (o - 256) / 16;
            if (o % 16 == 0) m_beat[c] = 20'(({12'd0, m_beat[c]} & ~m) | (d & m));
            else if (o % 16 == 4 && s[0]) begin
               if (d[0]) begin
                  if (m_busy[c]) m_err[c] = 1'b1;
                  else begin st[c] = 1'b1; m_busy[c] = 1'b1; end
               end
               if (d[1]) wb[c] = 1'b1;
            end else if (o % 16 == 8 && s[0] && d[2]) m_err[c] = 1'b0;
         end
      end
      for (int k = 0; k < NCH; k++)
         if (dm[k]) begin
            m_done[k] = 1'b1;
            if (!st[k]) m_busy[k] = 1'b0;
         end
   endfunction

   // ---------------- bus tasks ----------------
   // lead > 0: W presented lead cycles before AW; lead < 0: AW first
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input logic [3:0] dmask, input int bwait,
                            output logic [1:0] resp, output logic [3:0] st, output logic [3:0] wb);
      bit aw_ok = 0, w_ok = 0, af, wf;
      int cyc = 0;
      i_awaddr = a; i_wdata = d; i_wstrb = s;
      @(negedge i_clk);
      while (!(aw_ok && w_ok) && cyc < 40) begin
         if (w_ok && !aw_ok) check("wready_drop", o_wready, 0);
         if (aw_ok && !w_ok) check("awready_drop", o_awready, 0);
         i_awvalid = !aw_ok && cyc >= (lead > 0 ? lead : 0);
         i_wvalid  = !w_ok  && cyc >= (lead < 0 ? -lead : 0);
         af = i_awvalid && o_awready;
         wf = i_wvalid && o_wready;
         if ((aw_ok || af) && (w_ok || wf)) i_done = dmask;
         @(negedge i_clk);
         i_done = '0;
         aw_ok |= af; w_ok |= wf; cyc++;
      end
      i_awvalid = 0; i_wvalid = 0;
      check("wr_handshake", {aw_ok, w_ok}, 2'b11);
      check("bvalid_lat", o_bvalid, 1);
      st = o_start; wb = o_writeback; resp = o_bresp;
      for (int k = 0; k < bwait; k++) begin
         @(negedge i_clk);
         check("bvalid_hold", {o_bvalid, o_bresp}, {1'b1, resp});
      end
      i_bready = 1;
      @(negedge i_clk);
      i_bready = 0;
      check("b_single", o_bvalid, 0);
      if (bwait == 0) check("pulse_1cyc", {o_start, o_writeback}, 8'h00);
      check("rdy_back", {o_awready, o_wready}, 2'b11);
   endtask

   task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
      bit fired = 0;
      int cyc = 0;
      @(negedge i_clk);
      i_araddr = a; i_arvalid = 1;
      while (!fired && cyc < 40) begin
         fired = o_arready;
         @(negedge i_clk);
         cyc++;
      end
      i_arvalid = 0;
      check("ar_hs", fired, 1);
      check("rvalid_lat", o_rvalid, 1);
      check("arready_low", o_arready, 0);
      d = o_rdata; r = o_rresp;
      for (int k = 0; k < hold; k++) begin
         @(negedge i_clk);
         check("r_stable", {o_rvalid, o_rresp, o_rdata}, {1'b1, r, d});
      end
      i_rready = 1;
      @(negedge i_clk);
      i_rready = 0;
      check("rvalid_drop", o_rvalid, 0);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input logic [3:0] dmask, input int bwait);
      logic [1:0] resp, eresp;
      logic [3:0] st, wb, est, ewb;
      axi_write(a, d, s, lead, dmask, bwait, resp, st, wb);
      m_write(a, d, s, dmask, eresp, est, ewb);
      check("bresp", resp, eresp);
      check("start_pulse", st, est);
      check("wb_pulse", wb, ewb);
      check("beat_out", o_beat, {m_beat[3], m_beat[2], m_beat[1], m_beat[0]});
      check("irq", o_irq, |(m_done & m_irq_en));
   endtask

   task automatic do_read(input logic [31:0] a, input int hold);
      logic [31:0] d, ed;
      logic [1:0] r, er;
      axi_read(a, hold, d, r);
      m_read(a[11:0], ed, er);
      check("rresp", r, er);
      if (er == 2'b00) check("rdata", d, ed);
   endtask

   task automatic pulse_done(input logic [3:0] mask);
      @(negedge i_clk); i_done = mask;
      @(negedge i_clk); i_done = '0;
      m_done |= mask; m_busy &= ~mask;
      @(negedge i_clk);
      check("irq_done", o_irq, |(m_done & m_irq_en));
   endtask

   logic [31:0] rd;
   logic [1:0]  rr;
   logic [31:0] addr_list [10] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h100,
                                   32'h118, 32'h128, 32'h134, 32'h140, 32'h7F0};

   initial begin
      m_reset();
      // reset state
      repeat (3) @(negedge i_clk);
      check("rst_ready", {o_arready, o_awready, o_wready}, 3'b111);
      check("rst_valid", {o_rvalid, o_bvalid}, 2'b00);
      check("rst_outs", {o_beat, o_start, o_writeback, o_irq}, '0);
      check("rst_resp", {o_rdata, o_rresp, o_bresp}, '0);
      i_rst_n = 1;

      // ID register
      do_read(32'h000, 0);
      check("id_value", rd, rd);
      axi_read(32'h000, 0, rd, rr);
      check("id_explicit", {rr, rd}, {2'b00, 32'hA514_0402});

      // partial-strobe beat write, W three cycles ahead of AW
      do_write(32'h110, 32'h1234_5678, 4'b0011, 3, 4'h0, 0);
      check("beat_ch1", o_beat[39:20], 20'h05678);

      // start ch2, then repeat while busy
      do_write(32'h124, 32'h1, 4'hF, 0, 4'h0, 0);
      do_read(32'h128, 0);
      do_write(32'h124, 32'h1, 4'hF, -2, 4'h0, 1);
      axi_read(32'h128, 0, rd, rr);
      check("status_ch2_err", rd, 32'h5);

      // done / W1C / irq
      do_write(32'h004, 32'h4, 4'h1, 0, 4'h0, 0);
      pulse_done(4'h4);
      do_read(32'h008, 0);
      do_write(32'h008, 32'h4, 4'h1, 1, 4'h4, 0);
      axi_read(32'h008, 0, rd, rr);
      check("done_set_wins", rd, 32'h4);
      do_write(32'h008, 32'h4, 4'h1, 0, 4'h0, 0);
      check("irq_cleared", o_irq, 0);

      // unmapped accesses, long rready stall
      do_read(32'h140, 5);
      do_write(32'h7F0, 32'hFFFF_FFFF, 4'hF, 0, 4'h0, 0);
      do_read(32'h110, 0);

      // optional counter
`ifdef AXIREG_MC_PERF_EN
      do_write(32'h104, 32'h1, 4'h1, 0, 4'h0, 0);
      repeat (98) @(negedge i_clk);
      i_done = 4'h1;
      @(negedge i_clk);
      i_done = 4'h0;
      m_done[0] = 1'b1; m_busy[0] = 1'b0;
      repeat (3) @(negedge i_clk);
      axi_read(32'h10C, 0, rd, rr);
      check("perf_cnt", {rr, rd}, {2'b00, 32'd100});
`else
      axi_read(32'h10C, 0, rd, rr);
      check("perf_unmapped", rr, 2'b10);
`endif

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         logic [31:0] a, d;
         logic [3:0] s, dm;
         int kind, ch;
         kind = int'($urandom_range(0, 8));
         ch   = int'($urandom_range(0, 3));
         d    = $urandom;
         s    = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
         dm   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         case (kind)
            0: a = 32'h100 + 32'(16 * int'($urandom_range(0, 5)));
            1: a = 32'h004;
            2: a = 32'h008;
            3: begin a = 32'h104 + 32'(16 * ch); d = 32'($urandom_range(0, 3)); end
            4: begin a = 32'h108 + 32'(16 * ch); d = 32'h4; end
            5: a = addr_list[$urandom_range(0, 9)];
            default: a = 32'h0;
         endcase
         if (kind <= 5)
            do_write(a, d, s, int'($urandom_range(0, 6)) - 3, dm, int'($urandom_range(0, 2)));
         else if (kind == 6)
            pulse_done(4'($urandom_range(1, 15)));
         else begin
            a = addr_list[$urandom_range(0, 9)];
            if (PERF && a == 32'h00C) a = 32'h108;
            do_read(a, int'($urandom_range(0, 2)));
         end
      end

      // asynchronous reset in the middle of transactions
      @(negedge i_clk);
      i_araddr = 32'h0; i_arvalid = 1;
      i_awaddr = 32'h110; i_awvalid = 1;
      @(negedge i_clk);
      i_arvalid = 0;
      check("pre_rst_rvalid", o_rvalid, 1);
      #2 i_rst_n = 0;
      #1 check("rst_async_valid", {o_rvalid, o_bvalid}, 2'b00);
      i_awvalid = 0;
      m_reset();
      @(negedge i_clk);
      check("rst_mid_ready", {o_arready, o_awready, o_wready}, 3'b111);
      i_rst_n = 1;
      do_read(32'h110, 0);
      do_write(32'h118, 32'h5, 4'hF, 0, 4'h0, 0);
      do_read(32'h118, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
`default_nettype wire

// File: doc/axireg_mc.md
Name: axireg_mc

Overview:
- AXI4-Lite slave control/status register block for up to 16 independent sorting-network channels.
- Per channel: programmable beat count, start and writeback pulses, busy/done/error status.
- Global sticky done register (W1C), interrupt enable and a level interrupt output.
- Sits between the host AXI-Lite interconnect and the per-channel engine control inputs; data width is fixed at 32 bits.

Parameters:
- SADRW, 32, AXI address width (>=12); only addr[11:0] is decoded.
- NCH, 4, channel count, legal range 1..16.
- BEATW, 20, beat-count width, legal range 1..32.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_araddr  in  SADRW  read address.
- i_arvalid  in  1  read address valid.
- o_arready  out  1  read address ready.
- o_rdata  out  32  read data.
- o_rresp  out  2  read response.
- o_rvalid  out  1  read data valid.
- i_rready  in  1  read data ready.
- i_awaddr  in  SADRW  write address.
- i_awvalid  in  1  write address valid.
- o_awready  out  1  write address ready.
- i_wdata  in  32  write data.
- i_wstrb  in  4  write byte strobes.
- i_wvalid  in  1  write data valid.
- o_wready  out  1  write data ready.
- o_bresp  out  2  write response.
- o_bvalid  out  1  write response valid.
- i_bready  in  1  write response ready.
- o_beat  out  NCH*BEATW  per-channel beat count; channel c occupies [c*BEATW +: BEATW].
- o_start  out  NCH  one-cycle start pulse per channel.
- i_done  in  NCH  per-channel completion pulse or level.
- o_writeback  out  NCH  one-cycle writeback pulse per channel.
- o_irq  out  1  level interrupt.

Behaviour:
- Reset values:
  - Outputs: o_beat, o_start, o_writeback, o_irq, o_rvalid and o_bvalid all 0.
  - Responses and data: o_rresp = o_bresp = OKAY; o_rdata = 0.
  - Handshake readies: o_arready = 1, o_awready = 1, o_wready = 1.
  - Internal registers: all cleared.
- Register map (byte offsets, 32-bit aligned):
  - 0x000 ID (RO): {8'hA5, 8'(BEATW), 8'(NCH), 8'h02}.
  - 0x004 IRQ_EN (RW): bits [NCH-1:0].
  - 0x008 DONE (RO / W1C): bits [NCH-1:0].
  - Channel c base = 0x100 + 0x10*c.
  - +0x0 BEAT (RW): BEATW bits, zero-extended on read.
  - +0x4 CTRL (WO, reads 0): bit0 = start, bit1 = writeback.
  - +0x8 STATUS (RO): bit0 = busy, bit1 = done (mirror of DONE[c]), bit2 = err (sticky, cleared by writing 1 to STATUS bit2).
  - +0xC: see Optional Feature.
  - Any other offset, or a channel index >= NCH: unmapped.
- Write channel:
  - AW and W are accepted independently, in any order. Each ready drops after its own handshake; the write commits in the cycle where both have been captured.
  - o_bvalid rises the cycle after commit and holds until i_bready.
  - o_awready and o_wready return to 1 the cycle after the B handshake.
  - Only one write is outstanding at a time.
- Byte strobes:
  - Strobes merge bytewise into RW registers.
  - W1C and CTRL bits act only when byte lane 0 is strobed.
  - i_wstrb = 0 commits nothing and returns OKAY.
- Responses:
  - Unmapped addresses return SLVERR for both read and write; writes to them have no effect.
  - Writes to RO registers return OKAY and are ignored.
- Read channel:
  - o_arready = 1 while idle.
  - On AR handshake, data and response are registered; o_rvalid asserts the next cycle (1-cycle latency) and holds stable until i_rready.
  - o_arready = 0 while o_rvalid is high.
- Start and busy:
  - A CTRL start write on a channel with busy = 0 produces o_start[c] high for exactly 1 cycle (the cycle after commit) and sets busy.
  - If busy = 1, the start is suppressed and err is set.
  - The writeback pulse is always issued, also 1 cycle.
- Done:
  - i_done[c] high clears busy[c] and sets DONE[c]; it is edge-insensitive (every high cycle sets).
  - If i_done[c] arrives in the same cycle as a W1C of DONE[c], the set wins.
  - If i_done[c] arrives in the same cycle as a start commit, busy ends up at 1 (start wins) and DONE[c] is set.
- o_irq is registered: o_irq = |(DONE & IRQ_EN), updating 1 cycle after the change.
- Reset mid-transaction:
  - All handshakes abort, and valids drop asynchronously.
  - Any in-flight write is discarded.

Optional Feature:
- Macro: AXIREG_MC_PERF_EN.
- Defined:
  - Each channel gets a 32-bit cycle counter at +0xC (RO).
  - The counter clears on an accepted start and increments every cycle while busy; it saturates at 0xFFFFFFFF and holds its value after done.
- Undefined:
  - +0xC is unmapped (SLVERR) and no counter logic is built.

Test Plan:
- Reset, then read 0x000 with NCH=4, BEATW=20 -> rdata 0xA5140402, OKAY, rvalid exactly 1 cycle after AR handshake.
- Write 0x12345678 to 0x110 with wstrb=4'b0011, W presented 3 cycles before AW -> o_beat[39:20] = 0x05678, bresp OKAY, single B beat.
- Write 1 to 0x124 (ch2 start) -> o_start = 4'b0100 for 1 cycle; STATUS ch2 = 0x1. Repeat the start before done -> no pulse, STATUS = 0x5.
- With IRQ_EN = 0x4, pulse i_done[2] -> DONE = 0x4 and o_irq = 1. W1C 0x4 to 0x008 in the same cycle as a second i_done[2] -> DONE stays 0x4. Next W1C -> o_irq = 0.
- Read 0x140 (channel 4, unmapped with NCH=4) and write 0x7F0 -> SLVERR on both, no register changes. Hold rready low for 5 cycles -> rdata and rvalid stable.
- With PERF_EN defined: start ch0, i_done[0] 100 cycles later -> 0x10C reads 100 (±0 per the defined count rule). Without PERF_EN -> 0x10C returns SLVERR.
